// File: rtl/rob_pkg.sv
// Shared reorder-buffer constants and the write-back payload type.
// Used by the write-back arbiter and by the reorder buffer itself.
// Must stay identical on both sides of the ROB write port.
package rob_pkg;

  localparam int DATA_W    = 16;
  localparam int TAG_W     = 5;
  localparam int ROB_DEPTH = 32;

  // One write-back result as it is presented to the ROB write port.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  dest;
  } rob_wb_t;

endpackage : rob_pkg

// File: rtl/rr_arbiter.sv
// Purpose: round-robin one-hot arbiter; priority starts just after the last winner.
// Latency: grant is combinational from req/enable; the pointer updates on the clock edge.
// Backpressure: enable low forces no grant and freezes the pointer.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             enable,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan requests starting one past the last winner, wrapping, first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    if (enable) begin
      for (int k = 1; k <= N; k++) begin
        cand = IDX_W'((int'(last_q) + k) % N);
        if (!found && req[cand]) begin
          found     = 1'b1;
          gnt[cand] = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
    last_d = found ? gnt_idx : last_q;
  end

  // Pointer reset to the top unit so unit 0 is first in line after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= IDX_W'(N - 1);
    else          last_q <= last_d;
  end

endmodule : rr_arbiter

// File: rtl/rob_wb_arbiter.sv
// Purpose: shares the single ROB write port between NUM_REQ units, gated by free-entry credits.
// Latency: one cycle from req_valid&req_ready to the registered rob_write_en strobe.
// Backpressure: req_ready is withheld from all units while no credit remains (rob_full).
module rob_wb_arbiter
  import rob_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = rob_pkg::DATA_W,
  parameter int TAG_W     = rob_pkg::TAG_W,
  parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH,
  parameter int CNT_W     = $clog2(ROB_DEPTH) + 1,
  parameter int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*TAG_W-1:0]  req_dest,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         rob_write_data,
  output logic [TAG_W-1:0]          rob_entry,
  output logic                      rob_write_en,
  output logic [IDX_W-1:0]          grant_idx,
  input  logic                      commit_en,
  output logic [CNT_W-1:0]          free_count,
  output logic                      rob_full,
  output logic                      err_underflow
);

  // The payload register uses the shared ROB struct, so DATA_W/TAG_W
  // here must match the rob_pkg values the reorder buffer is built with.
  rob_wb_t          wb_q, wb_d;
  logic             wen_q, wen_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [CNT_W-1:0] free_q, free_d;
  logic             err_q, err_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               xfer;
  logic               at_max;
  logic               commit_ok;

  assign rob_full = (free_q == '0);
  assign at_max   = (free_q == CNT_W'(ROB_DEPTH));

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .enable  (!rob_full),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign req_ready = arb_gnt;

  // A grant is only ever issued to a valid requester, so any grant is a transfer.
  always_comb begin
    xfer      = |(req_valid & arb_gnt);
    commit_ok = commit_en & !at_max;
    // Commit only returns credit for the next cycle; it never unblocks this one.
    free_d    = free_q - CNT_W'(xfer) + CNT_W'(commit_ok);
    err_d     = err_q | (commit_en & at_max);
    wen_d     = xfer;
    wb_d      = wb_q;
    gidx_d    = gidx_q;
    if (xfer) begin
      wb_d.data = req_data[int'(arb_idx)*DATA_W +: DATA_W];
      wb_d.dest = req_dest[int'(arb_idx)*TAG_W +: TAG_W];
      gidx_d    = arb_idx;
    end
  end

  // Write strobe, payload, credits and the sticky error; async reset drops any pending write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wen_q  <= 1'b0;
      wb_q   <= '0;
      gidx_q <= '0;
      free_q <= CNT_W'(ROB_DEPTH);
      err_q  <= 1'b0;
    end else begin
      wen_q  <= wen_d;
      wb_q   <= wb_d;
      gidx_q <= gidx_d;
      free_q <= free_d;
      err_q  <= err_d;
    end
  end

  assign rob_write_en   = wen_q;
  assign rob_write_data = wb_q.data;
  assign rob_entry      = wb_q.dest;
  assign grant_idx      = gidx_q;
  assign free_count     = free_q;
  assign err_underflow  = err_q;

endmodule : rob_wb_arbiter

// File: tb/tb_rob_wb_arbiter.sv
module tb_rob_wb_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TW = 5;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N*TW-1:0] req_dest;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   rob_write_data;
  logic [TW-1:0]   rob_entry;
  logic            rob_write_en;
  logic [1:0]      grant_idx;
  logic            commit_en;
  logic [5:0]      free_count;
  logic            rob_full;
  logic            err_underflow;

  rob_wb_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_dest       (req_dest),
    .req_ready      (req_ready),
    .rob_write_data (rob_write_data),
    .rob_entry      (rob_entry),
    .rob_write_en   (rob_write_en),
    .grant_idx      (grant_idx),
    .commit_en      (commit_en),
    .free_count     (free_count),
    .rob_full       (rob_full),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic [1:0]    i;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] unit_data [N];
  logic [TW-1:0] unit_dest [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [TW-1:0] t, input logic [1:0] i);
    exp_t e;
    e.d = d; e.t = t; e.i = i;
    q.push_back(e);
  endtask

  task automatic set_unit(input int i, input logic [DW-1:0] d, input logic [TW-1:0] t);
    req_data[i*DW +: DW] = d;
    req_dest[i*TW +: TW] = t;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req_valid = '0;
    commit_en = 1'b0;
    @(posedge clk); #3 reset_n = 1'b0;
    @(posedge clk); #3 reset_n = 1'b1;
  endtask

  // Monitor: every ROB write must match the oldest expected transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rob_write_en) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got data %0h idx %0d expected no write", rob_write_data, grant_idx);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wb_data",  32'(rob_write_data), 32'(e.d));
          chk("wb_entry", 32'(rob_entry),      32'(e.t));
          chk("wb_idx",   32'(grant_idx),      32'(e.i));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      unit_data[i] = 16'hA000 + 16'(i);
      unit_dest[i] = 5'(10 + i);
    end
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_dest  = '0;
    commit_en = 1'b0;

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen",   32'(rob_write_en),   32'd0);
    chk("rst_data",  32'(rob_write_data), 32'd0);
    chk("rst_entry", 32'(rob_entry),      32'd0);
    chk("rst_gidx",  32'(grant_idx),      32'd0);
    chk("rst_free",  32'(free_count),     32'd32);
    @(negedge clk) reset_n = 1'b1;

    // Idle after reset for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_free", 32'(free_count),    32'd32);
      chk("idle_full", 32'(rob_full),      32'd0);
      chk("idle_wen",  32'(rob_write_en),  32'd0);
      chk("idle_err",  32'(err_underflow), 32'd0);
    end

    // Single request from unit 2.
    tick;
    set_unit(2, 16'h1234, 5'd7);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'b0100);
    push(16'h1234, 5'd7, 2'd2);
    tick;
    req_valid = '0;
    chk("single_wen",  32'(rob_write_en), 32'd1);
    chk("single_free", 32'(free_count),   32'd31);

    // Contention then full backpressure: 32 grants, rotation 0,1,2,3,...
    do_reset;
    tick;
    for (int i = 0; i < N; i++) set_unit(i, unit_data[i], unit_dest[i]);
    req_valid = 4'b1111;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("rot_ready", 32'(req_ready),  32'(4'b0001 << (k % 4)));
      chk("rot_free",  32'(free_count), 32'(32 - k));
      push(unit_data[k % 4], unit_dest[k % 4], 2'(k % 4));
      tick;
    end
    @(negedge clk);
    chk("full_free",  32'(free_count), 32'd0);
    chk("full_flag",  32'(rob_full),   32'd1);
    chk("full_ready", 32'(req_ready),  32'd0);
    tick;
    @(negedge clk);
    chk("full_ready2", 32'(req_ready),    32'd0);
    chk("full_nowen",  32'(rob_write_en), 32'd0);
    tick;
    commit_en = 1'b1;
    @(negedge clk);
    chk("commit_same_cycle_ready", 32'(req_ready), 32'd0);
    tick;
    commit_en = 1'b0;
    @(negedge clk);
    chk("commit_free",  32'(free_count), 32'd1);
    chk("commit_ready", 32'(req_ready),  32'b0001);
    push(unit_data[0], unit_dest[0], 2'd0);
    tick;
    @(negedge clk);
    chk("regrant_free",  32'(free_count), 32'd0);
    chk("regrant_ready", 32'(req_ready),  32'd0);

    // Grant and commit together at free_count == 1.
    tick;
    commit_en = 1'b1;
    @(negedge clk);
    chk("sim_pre_ready", 32'(req_ready), 32'd0);
    tick;
    @(negedge clk);
    chk("sim_free_before", 32'(free_count), 32'd1);
    chk("sim_ready",       32'(req_ready),  32'b0010);
    push(unit_data[1], unit_dest[1], 2'd1);
    tick;
    commit_en = 1'b0;
    req_valid = '0;
    chk("sim_free_after", 32'(free_count),   32'd1);
    chk("sim_wen",        32'(rob_write_en), 32'd1);

    // Underflow: commit at full credit.
    do_reset;
    tick;
    commit_en = 1'b1;
    tick;
    commit_en = 1'b0;
    chk("uf_free", 32'(free_count),    32'd32);
    chk("uf_err",  32'(err_underflow), 32'd1);
    tick;
    chk("uf_sticky", 32'(err_underflow), 32'd1);

    // Mid-stream async reset drops the pending write.
    req_valid = 4'b0010;
    @(negedge clk);
    chk("mid_ready", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1;
    chk("mid_wen_before", 32'(rob_write_en), 32'd1);
    req_valid = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("mid_wen_dropped", 32'(rob_write_en),   32'd0);
    chk("mid_err_clear",   32'(err_underflow),  32'd0);
    chk("mid_free",        32'(free_count),     32'd32);
    chk("mid_data",        32'(rob_write_data), 32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b0001);
    push(unit_data[0], unit_dest[0], 2'd0);
    tick;
    req_valid = '0;
    chk("post_rst_free", 32'(free_count), 32'd31);

    repeat (3) tick;
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rob_wb_arbiter
